// File: rtl/ram_coef_reader_pkg.sv
// Shared constants, FSM encoding and unpack helper for the RAM coefficient reader.
package ram_coef_reader_pkg;

    localparam int COEF_W         = 12;
    localparam int WORD_W         = 96;
    localparam int ADDR_W         = 8;
    localparam int COEFS_PER_WORD = 8;
    localparam int NW_W           = 7;
    localparam int IDX_W          = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Coefficient idx of a packed RAM word; idx 0 sits in the LSBs.
    function automatic logic [COEF_W-1:0] coef_slice(input logic [WORD_W-1:0] word,
                                                     input logic [IDX_W-1:0]  idx);
        return word[int'(idx)*COEF_W +: COEF_W];
    endfunction

endpackage

// File: rtl/ram_coef_reader_word_fifo.sv
// Two-entry FIFO holding returned RAM words until they are fully unpacked.
module word_fifo_2x96
    import ram_coef_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WORD_W-1:0] din,
    output logic [WORD_W-1:0] dout,
    output logic              full,
    output logic              empty,
    output logic [1:0]        count
);

    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic              do_push;
    logic              do_pop;

    // Overflow and underflow requests are dropped rather than corrupting pointers.
    assign do_push = push && (count != 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    assign dout    = mem[rd_ptr];
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);

    // Storage, pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ram_coef_reader.sv
// Streams n_words consecutive RAM words as 8 coefficients each over a valid/ready port.
module ram_coef_reader
    import ram_coef_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] r_start_offset,
    input  logic [NW_W-1:0]   n_words,
    output logic [ADDR_W-1:0] ram_raddr,
    input  logic [WORD_W-1:0] ram_rdata,
    output logic [COEF_W-1:0] coef_out,
    output logic              coef_valid,
    input  logic              coef_ready,
    output logic              coef_last,
    output logic              busy,
    output logic              finish
);

    state_t            state;
    logic [NW_W-1:0]   n_lat;
    logic [NW_W-1:0]   issued;
    logic [NW_W-1:0]   popped;
    logic [IDX_W-1:0]  idx;
    logic              rd_addr_q;
    logic              rd_data_q;

    logic [WORD_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_count;
    logic [2:0]        in_use;
    logic              issue;
    logic              load;
    logic              pop;
    logic              xfer_last;

    // A read occupies rd_addr_q while its address is on the bus and rd_data_q
    // while its data is on ram_rdata; both count against the 2-word budget.
    assign in_use    = {1'b0, fifo_count} + {2'b00, rd_addr_q} + {2'b00, rd_data_q};
    assign issue     = (state == ST_RUN) && (issued != n_lat) && (in_use < 3'd2) && !fifo_full;
    assign load      = (state == ST_RUN) && !fifo_empty && (!coef_valid || coef_ready);
    assign pop       = load && (idx == IDX_W'(COEFS_PER_WORD - 1));
    assign xfer_last = coef_valid && coef_ready && coef_last;

    word_fifo_2x96 u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_data_q),
        .pop   (pop),
        .din   (ram_rdata),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Job FSM, read issue, unpack stage and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ram_raddr  <= '0;
            coef_out   <= '0;
            coef_valid <= 1'b0;
            coef_last  <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b0;
            n_lat      <= '0;
            issued     <= '0;
            popped     <= '0;
            idx        <= '0;
            rd_addr_q  <= 1'b0;
            rd_data_q  <= 1'b0;
        end else begin
            rd_data_q <= rd_addr_q;
            rd_addr_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        n_lat  <= n_words;
                        popped <= '0;
                        idx    <= '0;
                        busy   <= 1'b1;
                        if (n_words != 7'd0) begin
                            state     <= ST_RUN;
                            ram_raddr <= r_start_offset;
                            rd_addr_q <= 1'b1;
                            issued    <= 7'd1;
                        end else begin
                            state  <= ST_DONE;
                            finish <= 1'b1;
                            issued <= 7'd0;
                        end
                    end
                end
                ST_RUN: begin
                    if (issue) begin
                        ram_raddr <= ram_raddr + 8'd1;
                        rd_addr_q <= 1'b1;
                        issued    <= issued + 7'd1;
                    end
                    if (load) begin
                        coef_out   <= coef_slice(fifo_dout, idx);
                        coef_valid <= 1'b1;
                        coef_last  <= pop && (popped == (n_lat - 7'd1));
                        idx        <= idx + 3'd1;
                        if (pop) begin
                            popped <= popped + 7'd1;
                        end
                    end else if (coef_valid && coef_ready) begin
                        coef_valid <= 1'b0;
                        coef_last  <= 1'b0;
                    end
                    if (xfer_last) begin
                        state  <= ST_DONE;
                        finish <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    finish <= 1'b0;
                end
                default: begin
                    state  <= ST_IDLE;
                    busy   <= 1'b0;
                    finish <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_coef_reader.sv
// Randomized scoreboard bench for ram_coef_reader with a behavioural RAM and job model.
module tb_ram_coef_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  r_start_offset;
    logic [6:0]  n_words;
    logic [7:0]  ram_raddr;
    logic [95:0] ram_rdata;
    logic [11:0] coef_out;
    logic        coef_valid;
    logic        coef_ready;
    logic        coef_last;
    logic        busy;
    logic        finish;

    ram_coef_reader dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .r_start_offset (r_start_offset),
        .n_words        (n_words),
        .ram_raddr      (ram_raddr),
        .ram_rdata      (ram_rdata),
        .coef_out       (coef_out),
        .coef_valid     (coef_valid),
        .coef_ready     (coef_ready),
        .coef_last      (coef_last),
        .busy           (busy),
        .finish         (finish)
    );

    always #5 clk = ~clk;

    logic [95:0] mem [256];
    always @(posedge clk) ram_rdata <= mem[ram_raddr];

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rdy_mode = 0;
    bit          mon_en = 1'b0;
    logic [12:0] exp_q [$];
    logic [7:0]  addr_q [$];
    int          issued_job = 0;
    int          xfer_job = 0;
    bit          vseen = 1'b0;
    int          first_valid_cyc = 0;
    int          last_xfer_cyc = 0;
    logic [7:0]  prev_raddr = 8'h00;
    logic [7:0]  last_addr = 8'h00;
    bit          prev_stall = 1'b0;
    logic [13:0] prev_out = 14'h0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        coef_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            coef_ready = (rdy_mode == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: read addresses, read budget, hold behaviour and coefficient scoreboard.
    initial forever begin
        @(negedge clk);
        if (mon_en) begin
            if (ram_raddr != prev_raddr) begin
                issued_job++;
                if (addr_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL extra_read: got addr %0h expected none", ram_raddr);
                end else begin
                    chk("read_addr", ram_raddr, addr_q.pop_front());
                end
            end
            chk("reads_ahead_le2", ((issued_job - (xfer_job + int'(coef_valid)) / 8) <= 2), 1);
            if (prev_stall) chk("hold_while_stalled", {coef_valid, coef_last, coef_out}, prev_out);
            if (coef_valid && !vseen) begin
                vseen = 1'b1;
                first_valid_cyc = cyc;
            end
            if (coef_valid && coef_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL spurious_coef: got %0h expected none", coef_out);
                end else begin
                    chk("coef_last_value", {coef_last, coef_out}, exp_q.pop_front());
                end
                xfer_job++;
                last_xfer_cyc = cyc;
            end
            prev_stall = coef_valid && !coef_ready;
            prev_out   = {coef_valid, coef_last, coef_out};
        end else begin
            prev_stall = 1'b0;
        end
        prev_raddr = ram_raddr;
    end

    task automatic start_job(input logic [7:0] off, input int n, input bit use_fixed,
                             input logic [95:0] fixed_word, output int acc);
        for (int w = 0; w < n; w++) begin
            logic [7:0]  a;
            logic [95:0] word;
            a = off + 8'(w);
            word = use_fixed ? fixed_word : {$urandom, $urandom, $urandom};
            mem[a] = word;
            addr_q.push_back(a);
            for (int k = 0; k < 8; k++) begin
                exp_q.push_back({(w == n - 1) && (k == 7), word[12*k +: 12]});
            end
        end
        issued_job = 0;
        xfer_job   = 0;
        vseen      = 1'b0;
        if (n > 0) last_addr = off + 8'(n - 1);
        @(posedge clk);
        #1;
        start          = 1'b1;
        r_start_offset = off;
        n_words        = 7'(n);
        acc            = cyc + 1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int acc, input int n, input bit timing);
        int t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!finish && t < 4000);
        if (!finish) begin
            n_vec++;
            n_err++;
            $display("FAIL finish_timeout: got no finish expected finish within 4000 cycles");
        end else begin
            if (timing) begin
                if (n == 0) begin
                    chk("finish_cycle_empty", cyc, acc);
                end else begin
                    chk("first_valid_cycle", first_valid_cyc, acc + 3);
                    chk("last_xfer_cycle", last_xfer_cyc, acc + 2 + 8 * n);
                    chk("finish_cycle", cyc, acc + 3 + 8 * n);
                end
            end
            chk("coefs_remaining", exp_q.size(), 0);
            chk("reads_remaining", addr_q.size(), 0);
            chk("transfer_count", xfer_job, 8 * n);
            if (n == 0) chk("valid_never_high", vseen, 0);
            @(negedge clk);
            chk("finish_one_cycle", finish, 0);
            chk("idle_after_done", busy, 0);
        end
    endtask

    task automatic run_job(input logic [7:0] off, input int n, input bit timing, input bit glitch);
        int acc;
        logic [7:0] o;
        o = off;
        if (n > 0 && o == last_addr) o = o + 8'd1;
        start_job(o, n, 1'b0, 96'h0, acc);
        fork
            wait_done(acc, n, timing);
            begin
                if (glitch) begin
                    repeat (6) @(posedge clk);
                    #1;
                    start          = 1'b1;
                    r_start_offset = 8'hAA;
                    n_words        = 7'd3;
                    @(posedge clk);
                    #1;
                    start = 1'b0;
                end
            end
        join
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_raddr"}, ram_raddr, 0);
        chk({tag, "_coef_out"}, coef_out, 0);
        chk({tag, "_valid"}, coef_valid, 0);
        chk({tag, "_last"}, coef_last, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_finish"}, finish, 0);
    endtask

    initial begin
        int acc;
        int t;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        rst = 1'b1;
        start = 1'b0;
        r_start_offset = 8'h00;
        n_words = 7'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        rst = 1'b0;
        mon_en = 1'b1;

        // Known word, ready held high: exact latency and throughput.
        rdy_mode = 0;
        start_job(8'h10, 1, 1'b1, 96'h00B00A009008007006005004, acc);
        wait_done(acc, 1, 1'b1);
        run_job(8'hFE, 4, 1'b1, 1'b0);
        run_job(8'h00, 0, 1'b1, 1'b0);

        rdy_mode = 1;
        run_job(8'h40, 4, 1'b0, 1'b1);
        run_job(8'($urandom_range(0, 255)), 64, 1'b0, 1'b0);

        // Abort a two-word job at its fifth transfer.
        rdy_mode = 0;
        start_job(8'h80, 2, 1'b0, 96'h0, acc);
        t = 0;
        while (xfer_job < 5 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (xfer_job < 5) begin
            n_vec++;
            n_err++;
            $display("FAIL abort_wait: got %0d transfers expected 5", xfer_job);
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_zero("abort");
        rst = 1'b0;
        exp_q.delete();
        addr_q.delete();
        issued_job = 0;
        xfer_job = 0;
        last_addr = 8'h00;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_finish", finish, 0);
            chk("abort_no_valid", coef_valid, 0);
        end
        mon_en = 1'b1;
        rdy_mode = 1;
        run_job(8'h33, 3, 1'b0, 1'b0);

        for (int j = 0; j < 6; j++) begin
            rdy_mode = j % 2;
            run_job(8'($urandom_range(0, 255)), $urandom_range(0, 64), 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
